pkt_proc_ctrl: RTL

Packet-level sequencer between the input stream, `fifo_sram` and the `datapath` CPU. It runs one packet at a time: accept the packet into the SRAM FIFO, freeze input and assert `pc_en` so the CPU processes the buffered words in place, then drain exactly that packet to the output. It replaces the free-running `pc_en`/`in_rdy`/`reb` glue currently wired at top level.

---
 rtl/pkt_proc_ctrl_if.sv | 26 ++
 rtl/pkt_proc_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/pkt_proc_ctrl_if.sv
// Stream and FIFO-side handshake bundle for pkt_proc_ctrl.
interface pkt_proc_ctrl_if #(
  parameter int CTRL_WIDTH = 8
);
  // Input word moves when in_wr & in_rdy are both high on a rising edge; in_wr
  // while in_rdy is low is not a transfer. A FIFO read happens on every edge
  // where fifo_reb is high, and out_wr mirrors it as the downstream valid.
  logic                  in_wr;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_rdy;
  logic                  fifo_almfull;
  logic                  fifo_empty;
  logic                  fifo_reb;
  logic                  out_rdy;
  logic                  out_wr;

  modport master (
    output in_wr, in_ctrl, fifo_almfull, fifo_empty, out_rdy,
    input  in_rdy, fifo_reb, out_wr
  );

  modport slave (
    input  in_wr, in_ctrl, fifo_almfull, fifo_empty, out_rdy,
    output in_rdy, fifo_reb, out_wr
  );
endinterface

// File: rtl/pkt_proc_ctrl.sv
// One-packet-at-a-time sequencer: fill the SRAM FIFO, let the CPU process the
// buffered words in place, then drain exactly that packet downstream.
module pkt_proc_ctrl #(
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 10,
  parameter int TO_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  pkt_proc_ctrl_if.slave      bus,
  output logic                pc_en,
  input  logic                cpu_done,
  input  logic [TO_WIDTH-1:0] timeout_cycles,
  output logic [1:0]          state,
  output logic [31:0]         pkt_count,
  output logic [15:0]         timeout_count,
  output logic [1:0]          err_flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_PROC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [CTRL_WIDTH-1:0] CTRL_DATA = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0]   TO_ONE    = TO_WIDTH'(1);

  state_t                cur, nxt;
  logic                  seen_data;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic [CNT_WIDTH-1:0]  drain_cnt;
  logic [TO_WIDTH-1:0]   timer;

  logic rdy, reb, accept, is_data, eop, full_hit, to_hit, rd_last;

  assign rdy      = ((cur == S_IDLE) || (cur == S_FILL)) && !bus.fifo_almfull;
  assign accept   = bus.in_wr && rdy;
  assign is_data  = (bus.in_ctrl == CTRL_DATA);
  // seen_data is clear in IDLE, so a packet's first word never closes it.
  assign eop      = accept && !is_data && seen_data;
  assign full_hit = (cur == S_FILL) && accept && !eop && (word_cnt == CNT_MAX - CNT_ONE);
  assign to_hit   = (timeout_cycles != '0) && (timer == timeout_cycles - TO_ONE);
  assign reb      = (cur == S_DRAIN) && bus.out_rdy && !bus.fifo_empty && (drain_cnt != '0);
  assign rd_last  = reb && (drain_cnt == CNT_ONE);

  assign bus.in_rdy   = rdy;
  assign bus.fifo_reb = reb;
  assign bus.out_wr   = reb;
  assign state        = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:  if (accept)              nxt = S_FILL;
      S_FILL:  if (eop || full_hit)     nxt = S_PROC;
      S_PROC:  if (cpu_done || to_hit)  nxt = S_DRAIN;
      S_DRAIN: if (rd_last)             nxt = S_IDLE;
      default:                          nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_en         <= 1'b0;
      pkt_count     <= '0;
      timeout_count <= '0;
      err_flags     <= '0;
      seen_data     <= 1'b0;
      word_cnt      <= '0;
      drain_cnt     <= '0;
      timer         <= '0;
    end else begin
      pc_en <= (nxt == S_PROC);
      if (bus.in_wr && !rdy) err_flags[0] <= 1'b1;
      if (full_hit)          err_flags[1] <= 1'b1;

      unique case (cur)
        S_IDLE: begin
          if (accept) begin
            word_cnt  <= CNT_ONE;
            seen_data <= is_data;
          end
        end
        S_FILL: begin
          // Held at zero so the first PROC cycle sees timer == 0.
          timer <= '0;
          if (accept) begin
            word_cnt <= word_cnt + CNT_ONE;
            if (is_data) seen_data <= 1'b1;
          end
        end
        S_PROC: begin
          timer <= timer + TO_ONE;
          if (nxt == S_DRAIN) drain_cnt <= word_cnt;
          if (to_hit && !cpu_done) timeout_count <= timeout_count + 16'd1;
        end
        S_DRAIN: begin
          if (reb) drain_cnt <= drain_cnt - CNT_ONE;
          if (rd_last) begin
            pkt_count <= pkt_count + 32'd1;
            seen_data <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
